wm_panel_unit: RTL and testbench
================================

# wm_panel_unit

Front-panel support block for the washing-machine controller. It groups three functions:

- **Tick generator:** derives 1 Hz and 10 kHz enable strobes from the 100 MHz system clock.
- **Wash-model selector:** steps through the wash programs on each press of the model button.
- **Display scanner:** multiplexes a 4-digit, 7-segment, active-low display that shows remaining and total wash time.

It sits between the board I/O and the program/time control logic. That logic consumes `current_model` and the 1 Hz strobe and supplies the time and water values.

## Interface
- `DIV_1HZ`, default 100_000_000: clk cycles per `tick_1hz` period.
- `DIV_SCAN`, default 10_000: clk cycles per `tick_scan` period (10 kHz at 100 MHz).
- `clk` input, 1 bit: 100 MHz system clock.
- `reset` input, 1 bit: asynchronous, active-high reset.
- `power_on` input, 1 bit: machine powered; 0 forces the model to 0 and blanks the display.
- `run_state` input, 2 bits: 00 idle, 01 running, 10 paused, 11 reserved.
- `finish` input, 1 bit: wash cycle complete.
- `model_choose` input, 1 bit: asynchronous model button, level high while pressed.
- `current_time` input, 7 bits: remaining minutes.
- `total_time` input, 7 bits: total minutes.
- `current_water` input, 3 bits: water level, 0–5.
- `current_model` output, 3 bits: selected wash model, 0–5.
- `tick_1hz` output, 1 bit: one-cycle strobe at 1 Hz.
- `tick_scan` output, 1 bit: one-cycle strobe at 10 kHz.
- `digit_show` output, 8 bits: active-low segments, bit order {dp,g,f,e,d,c,b,a}.
- `AN` output, 4 bits: active-low digit enables; `AN[0]` is the rightmost digit.

## Operation
**Tick generator**
- Two free-running counters. Each counts from 0 to DIV−1, then wraps to 0.
- The corresponding strobe is high for exactly the one clk cycle in which the counter wraps.
- The tick counters are not affected by `power_on`.

**Model selector**
- `model_choose` is synchronised through 2 flip-flops, then rising-edge detected.
- A detected edge increments `current_model` only when all of these hold: `power_on`=1, `run_state`=00 and `finish`=0.
- The sequence is 0,1,2,3,4,5,0,…; an increment from 5 wraps to 0.
- In all other conditions the edge is ignored.
- While `power_on`=0, `current_model` is held at 0 synchronously.
- Holding the button does not repeat the increment; one edge gives one step.

**Display scanner**
- A 2-bit digit index advances on each `tick_scan` in the order 0,1,2,3,0,…
- Digit values are formed as follows:
  - Digit 1 = tens of `current_time`; digit 0 = units of `current_time`.
  - Digit 3 = tens of `total_time`; digit 2 = units of `total_time`.
  - Time inputs above 99 are clamped to 99 before splitting into tens and units.
- Leading zeros are shown, not blanked.
- Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex). Any other digit value gives FF.
- The decimal point (dp) is always off (1).
- `AN` drives exactly one bit low: the bit of the current digit index.
- While `power_on`=0: `AN`=1111 and `digit_show`=FF.

## Timing
- **Reset values:** tick counters 0, `tick_1hz`=0, `tick_scan`=0, `current_model`=0, digit index 0, `AN`=1111, `digit_show`=FF.
- **First strobes:** the first `tick_scan` occurs DIV_SCAN cycles after reset is released; the first `tick_1hz` occurs DIV_1HZ cycles after release.
- **Model latency:** `current_model` updates 3 clk cycles after the `model_choose` rising edge reaches the input (2 sync stages plus 1 edge/update register).
- **Display update:** `AN` and `digit_show` are registered and change on the cycle after `tick_scan`. Input time changes are visible at the next scan of the affected digit.
- **Power loss:** a `power_on` fall blanks the display on the next clk edge, and the model reads 0 on the same edge.
- **Reset mid-operation:** all state returns immediately (asynchronously) to the reset values.

## Configuration
- **`WATER_DISPLAY_EN`**
  - When defined: digit 3 shows `current_water` (0–5) and digit 2 shows `current_model`+1 (1–6). Digits 1:0 are unchanged.
  - When undefined: digits 3:2 show `total_time`, as described under Operation.

## Test plan
- **Tick periods:** with DIV_1HZ=20 and DIV_SCAN=4, release reset.
  - `tick_scan` pulses every 4 cycles; `tick_1hz` pulses every 20 cycles.
  - Every pulse is 1 cycle wide.
- **Model cycling:** `power_on`=1, `run_state`=00, `finish`=0; apply 7 `model_choose` pulses.
  - `current_model` goes 1,2,3,4,5,0,1.
  - A button held for 50 cycles gives 1 step.
- **Model lockout:**
  - With `run_state`=01, a pulse leaves the model at 2.
  - With `finish`=1, a pulse leaves the model at 2.
  - Setting `power_on`=0 makes `current_model`=0.
- **Scan content:** `current_time`=37, `total_time`=45.
  - The 4 digits cycle as `AN`=1110/`digit_show`=F8, then 1101/B0, then 1011/92, then 0111/99.
  - `current_time`=120 displays as 99.
- **Blanking and reset:**
  - `power_on`=0 gives `AN`=1111 and `digit_show`=FF.
  - Asserting `reset` mid-scan immediately returns all outputs to their reset values.
- **`WATER_DISPLAY_EN` build:** `current_water`=3 and `current_model`=2.
  - Digit 3 shows B0 (3); digit 2 shows B0 (model+1=3).

Source files
------------

// File: rtl/wm_panel_unit.sv
`timescale 1ns/1ps
// Washing-machine front panel: 1 Hz / scan tick strobes, wash-model selector and
// 4-digit 7-segment scanner. Define WATER_DISPLAY_EN to show water level and model on digits 3:2.
module wm_panel_unit #(
  parameter int DIV_1HZ  = 100_000_000,
  parameter int DIV_SCAN = 10_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_on,
  input  logic [1:0] run_state,
  input  logic       finish,
  input  logic       model_choose,
  input  logic [6:0] current_time,
  input  logic [6:0] total_time,
  input  logic [2:0] current_water,
  output logic [2:0] current_model,
  output logic       tick_1hz,
  output logic       tick_scan,
  output logic [7:0] digit_show,
  output logic [3:0] AN
);

  localparam int W1 = (DIV_1HZ > 1) ? $clog2(DIV_1HZ) : 1;
  localparam int WS = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam logic [W1-1:0] LAST_1HZ  = W1'(DIV_1HZ - 1);
  localparam logic [WS-1:0] LAST_SCAN = WS'(DIV_SCAN - 1);

  logic [W1-1:0] cnt_1hz;
  logic [WS-1:0] cnt_scan;

  // Strobes are registered, so each lands exactly DIV cycles after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_1hz  <= '0;
      tick_1hz <= 1'b0;
    end else if (cnt_1hz == LAST_1HZ) begin
      cnt_1hz  <= '0;
      tick_1hz <= 1'b1;
    end else begin
      cnt_1hz  <= cnt_1hz + W1'(1);
      tick_1hz <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_scan  <= '0;
      tick_scan <= 1'b0;
    end else if (cnt_scan == LAST_SCAN) begin
      cnt_scan  <= '0;
      tick_scan <= 1'b1;
    end else begin
      cnt_scan  <= cnt_scan + WS'(1);
      tick_scan <= 1'b0;
    end
  end

  logic btn_s1, btn_s2, btn_q;
  logic btn_rise;
  assign btn_rise = btn_s2 & ~btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1        <= 1'b0;
      btn_s2        <= 1'b0;
      btn_q         <= 1'b0;
      current_model <= 3'd0;
    end else begin
      btn_s1 <= model_choose;
      btn_s2 <= btn_s1;
      btn_q  <= btn_s2;
      if (!power_on)
        current_model <= 3'd0;
      else if (btn_rise && run_state == 2'b00 && !finish)
        current_model <= (current_model == 3'd5) ? 3'd0 : current_model + 3'd1;
    end
  end

  function automatic logic [6:0] clamp99(input logic [6:0] t);
    return (t > 7'd99) ? 7'd99 : t;
  endfunction

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  logic [6:0] cur_c;
  logic [3:0] dig_hi, dig_lo, cur_digit;
  logic [1:0] idx;
  assign cur_c = clamp99(current_time);

`ifdef WATER_DISPLAY_EN
  logic unused_total;
  assign unused_total = ^total_time;
  assign dig_hi = {1'b0, current_water};
  assign dig_lo = {1'b0, current_model} + 4'd1;
`else
  logic [6:0] tot_c;
  logic       unused_water;
  assign unused_water = ^current_water;
  assign tot_c  = clamp99(total_time);
  assign dig_hi = 4'(tot_c / 7'd10);
  assign dig_lo = 4'(tot_c % 7'd10);
`endif

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      2'd0: cur_digit = 4'(cur_c % 7'd10);
      2'd1: cur_digit = 4'(cur_c / 7'd10);
      2'd2: cur_digit = dig_lo;
      2'd3: cur_digit = dig_hi;
      default: cur_digit = 4'd0;
    endcase
  end

  // Index keeps stepping while unpowered, so scanning resumes in phase with the tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= 2'd0;
      AN         <= 4'hF;
      digit_show <= 8'hFF;
    end else begin
      if (tick_scan)
        idx <= idx + 2'd1;
      if (!power_on) begin
        AN         <= 4'hF;
        digit_show <= 8'hFF;
      end else if (tick_scan) begin
        AN         <= ~(4'b0001 << idx);
        digit_show <= seg_code(cur_digit);
      end
    end
  end

endmodule

// File: tb/tb_wm_panel_unit.sv
`timescale 1ns/1ps
// Bench for wm_panel_unit: tick periods, model stepping/lockout, scan content, blanking, reset.
module tb_wm_panel_unit;
  localparam int DIV_1HZ  = 20;
  localparam int DIV_SCAN = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       power_on;
  logic [1:0] run_state;
  logic       finish;
  logic       model_choose;
  logic [6:0] current_time;
  logic [6:0] total_time;
  logic [2:0] current_water;
  logic [2:0] current_model;
  logic       tick_1hz;
  logic       tick_scan;
  logic [7:0] digit_show;
  logic [3:0] AN;

  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int exp_model;
  logic [7:0] seg_lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  wm_panel_unit #(.DIV_1HZ(DIV_1HZ), .DIV_SCAN(DIV_SCAN)) dut (
    .clk(clk), .reset(reset), .power_on(power_on), .run_state(run_state),
    .finish(finish), .model_choose(model_choose), .current_time(current_time),
    .total_time(total_time), .current_water(current_water),
    .current_model(current_model), .tick_1hz(tick_1hz), .tick_scan(tick_scan),
    .digit_show(digit_show), .AN(AN)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic int clamp(input int t);
    return (t > 99) ? 99 : t;
  endfunction

  function automatic logic [7:0] ref_seg(input int d);
    int v;
    case (d)
      0: v = clamp(int'(current_time)) % 10;
      1: v = clamp(int'(current_time)) / 10;
`ifdef WATER_DISPLAY_EN
      2: v = exp_model + 1;
      3: v = int'(current_water);
`else
      2: v = clamp(int'(total_time)) % 10;
      3: v = clamp(int'(total_time)) / 10;
`endif
      default: v = 15;
    endcase
    return (v < 10) ? seg_lut[v] : 8'hFF;
  endfunction

  // Display register loads on the edge after each scan tick: edge 4k+1 shows digit (k-1)%4.
  function automatic bit is_update(input int c);
    return (c >= DIV_SCAN + 1) && ((c - 1) % DIV_SCAN == 0);
  endfunction

  function automatic int upd_digit(input int c);
    return ((c - 1) / DIV_SCAN - 1) % 4;
  endfunction

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_model = 0;
  endtask

  task automatic press(input int hold);
    @(negedge clk);
    model_choose = 1'b1;
    repeat (hold) @(negedge clk);
    model_choose = 1'b0;
    repeat (6) @(negedge clk);
    if (!power_on) exp_model = 0;
    else if (run_state == 2'b00 && !finish) exp_model = (exp_model + 1) % 6;
  endtask

  // Returns 1 when positioned on the negedge just after a display update.
  task automatic wait_update(output bit ok);
    int n = 0;
    ok = 1'b0;
    while (n < 20 && !ok) begin
      @(negedge clk);
      n++;
      ok = is_update(cyc);
    end
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++;
    if (AN !== 4'hF || digit_show !== 8'hFF || current_model !== 3'd0 ||
        tick_scan !== 1'b0 || tick_1hz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_values: got AN=%b seg=%h model=%0d ticks=%b%b required 1111/ff/0/00",
               AN, digit_show, current_model, tick_1hz, tick_scan);
    end
  endtask

  task automatic test_ticks();
    do_reset();
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      vectors++;
      if (tick_scan !== (cyc > 0 && cyc % DIV_SCAN == 0)) begin
        miscompares++;
        $display("FAIL tick_scan cycle %0d: got %b required %b", cyc, tick_scan,
                 (cyc > 0 && cyc % DIV_SCAN == 0));
      end
      vectors++;
      if (tick_1hz !== (cyc > 0 && cyc % DIV_1HZ == 0)) begin
        miscompares++;
        $display("FAIL tick_1hz cycle %0d: got %b required %b", cyc, tick_1hz,
                 (cyc > 0 && cyc % DIV_1HZ == 0));
      end
    end
  endtask

  task automatic test_model_cycle();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      press(int'($urandom_range(1, 4)));
      vectors++;
      if (int'(current_model) !== exp_model) begin
        miscompares++;
        $display("FAIL model_cycle press %0d: got %0d required %0d", i, current_model, exp_model);
      end
    end
    press(50);
    vectors++;
    if (int'(current_model) !== exp_model || exp_model != 2) begin
      miscompares++;
      $display("FAIL model_hold: got %0d required 2", current_model);
    end
  endtask

  task automatic test_lockout();
    for (int i = 0; i < 4; i++) begin
      run_state = (i < 3) ? 2'(i + 1) : 2'b00;
      finish    = (i == 3);
      press(int'($urandom_range(1, 4)));
      vectors++;
      if (int'(current_model) !== exp_model) begin
        miscompares++;
        $display("FAIL lockout case %0d: got %0d required %0d", i, current_model, exp_model);
      end
    end
    run_state = 2'b00;
    finish = 1'b0;
    @(negedge clk);
    power_on = 1'b0;
    exp_model = 0;
    @(negedge clk);
    vectors++;
    if (current_model !== 3'd0 || AN !== 4'hF || digit_show !== 8'hFF) begin
      miscompares++;
      $display("FAIL power_off: got model=%0d AN=%b seg=%h required 0/1111/ff",
               current_model, AN, digit_show);
    end
    power_on = 1'b1;
  endtask

  task automatic test_latency();
    int old_model;
    @(negedge clk);
    old_model = exp_model;
    model_choose = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (int'(current_model) !== old_model) begin
      miscompares++;
      $display("FAIL latency_early: got %0d required %0d", current_model, old_model);
    end
    @(negedge clk);
    exp_model = (old_model + 1) % 6;
    vectors++;
    if (int'(current_model) !== exp_model) begin
      miscompares++;
      $display("FAIL latency_third_edge: got %0d required %0d", current_model, exp_model);
    end
    model_choose = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_random_model();
    for (int i = 0; i < 24; i++) begin
      power_on  = ($urandom_range(0, 3) != 0);
      run_state = 2'($urandom_range(0, 3));
      finish    = ($urandom_range(0, 3) == 0);
      press(int'($urandom_range(1, 6)));
      vectors++;
      if (int'(current_model) !== exp_model) begin
        miscompares++;
        $display("FAIL random_model %0d: got %0d required %0d", i, current_model, exp_model);
      end
    end
    power_on = 1'b1;
    run_state = 2'b00;
    finish = 1'b0;
  endtask

  task automatic check_scan(input string tag, input int n, input bit rnd);
    bit ok;
    int d;
    logic [3:0] exp_an;
    for (int i = 0; i < n; i++) begin
      wait_update(ok);
      vectors++;
      if (!ok) begin
        miscompares++;
        $display("FAIL %s_timeout: got no update required update within 20 cycles", tag);
      end else begin
        d = upd_digit(cyc);
        exp_an = 4'hF;
        exp_an[d] = 1'b0;
        if (AN !== exp_an || digit_show !== ref_seg(d)) begin
          miscompares++;
          $display("FAIL %s digit %0d: got AN=%b seg=%h required AN=%b seg=%h",
                   tag, d, AN, digit_show, exp_an, ref_seg(d));
        end
      end
      if (rnd) begin
        current_time  = 7'($urandom_range(0, 127));
        total_time    = 7'($urandom_range(0, 127));
        current_water = 3'($urandom_range(0, 5));
      end
    end
  endtask

  task automatic test_scan();
    do_reset();
    current_time = 7'd37;
    total_time = 7'd45;
    current_water = 3'd3;
    press(2);
    press(3);
    check_scan("scan_fixed", 8, 1'b0);
    current_time = 7'd120;
    check_scan("scan_clamp", 4, 1'b0);
    check_scan("scan_random", 20, 1'b1);
  endtask

  task automatic test_blank();
    bit ok;
    @(negedge clk);
    power_on = 1'b0;
    exp_model = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (AN !== 4'hF || digit_show !== 8'hFF || current_model !== 3'd0) begin
        miscompares++;
        $display("FAIL blank %0d: got AN=%b seg=%h model=%0d required 1111/ff/0",
                 i, AN, digit_show, current_model);
      end
      wait_update(ok);
    end
    power_on = 1'b1;
    check_scan("scan_repower", 4, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit ok;
    wait_update(ok);
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (AN !== 4'hF || digit_show !== 8'hFF || current_model !== 3'd0 ||
        tick_scan !== 1'b0 || tick_1hz !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got AN=%b seg=%h model=%0d ticks=%b%b required 1111/ff/0/00",
               AN, digit_show, current_model, tick_1hz, tick_scan);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_model = 0;
    check_scan("scan_after_reset", 4, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    power_on = 1'b1;
    run_state = 2'b00;
    finish = 1'b0;
    model_choose = 1'b0;
    current_time = 7'd0;
    total_time = 7'd0;
    current_water = 3'd0;
    exp_model = 0;
    test_reset();
    test_ticks();
    test_model_cycle();
    test_lockout();
    test_latency();
    test_random_model();
    test_scan();
    test_blank();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
